any1_rf_wr_arbiter: RTL and testbench

- Shares the single write port of an any1_regfile lane between NREQ writeback sources (ALU, memory, float, CSR units).
- Arbitration is round-robin with burst locking, so vector ops can write vl consecutive elements without interruption.
- Sits between the functional-unit result buses and the regfile wr/wa/i inputs.
- Output is registered: one write per clock maximum.

---
 rtl/any1_rf_wr_arbiter_if.sv | 32 +++
 rtl/any1_rf_wr_arbiter.sv | 128 ++++++++++++
 tb/tb_any1_rf_wr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/any1_rf_wr_arbiter_if.sv
// Bundle of requester-side handshake signals and regfile write-port outputs
// shared between the writeback sources and the any1 regfile write arbiter.
interface any1_rf_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int WID  = 64,
  parameter int RWID = 10,
  parameter int LENW = 8
);
  logic [NREQ-1:0]      req_i;
  logic [NREQ*RWID-1:0] rd_i;
  logic [NREQ*WID-1:0]  dat_i;
  logic [NREQ*LENW-1:0] len_i;
  logic [NREQ-1:0]      ack_o;
  logic                 rfwr_o;
  logic [RWID-1:0]      wa_o;
  logic [WID-1:0]       i_o;
  logic [LENW-1:0]      elem_o;
  logic [NREQ-1:0]      gnt_o;
  logic                 busy_o;

  // Writeback sources: drive requests, observe acks and the write port.
  modport master (
    output req_i, rd_i, dat_i, len_i,
    input  ack_o, rfwr_o, wa_o, i_o, elem_o, gnt_o, busy_o
  );

  // Arbiter side.
  modport slave (
    input  req_i, rd_i, dat_i, len_i,
    output ack_o, rfwr_o, wa_o, i_o, elem_o, gnt_o, busy_o
  );
endinterface

// File: rtl/any1_rf_wr_arbiter.sv
// Round-robin arbiter for the single write port of an any1 regfile lane.
// A granted requester with a burst length above one keeps the port until all
// of its beats have transferred, so vector results land without interruption.
// Writes to scalar r0 are acknowledged but never reach the regfile.
module any1_rf_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int WID  = 64,
  parameter int RWID = 10,
  parameter int LENW = 8
) (
  input logic clk_i,
  input logic rst_i,
  any1_rf_wr_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [RWID-1:0] R0_ADDR = RWID'({4'd15, 6'd0});

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_q;
  logic [LENW-1:0] remain_q;
  logic            rfwr_q;
  logic [RWID-1:0] wa_q;
  logic [WID-1:0]  dat_q;
  logic [LENW-1:0] elem_q;
  logic [NREQ-1:0] gnt_q;

  logic [NREQ-1:0] ack;
  logic            found;
  logic [PW-1:0]   idx;
  logic            xfer;
  logic [PW-1:0]   sel;
  logic [RWID-1:0] sel_rd;
  logic [WID-1:0]  sel_dat;
  logic [LENW-1:0] sel_len;
  logic [RWID-1:0] beat_addr;

  // State register; reset abandons any partial burst.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Enter BURST on a multi-beat first transfer, leave on the final beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer && (sel_len > LENW'(1))) state_d = BURST;
      BURST:   if (xfer && (remain_q == LENW'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Acks: rotating priority search in IDLE, only the locked owner in BURST.
  always_comb begin
    ack   = '0;
    found = 1'b0;
    idx   = '0;
    if (state_q == BURST) begin
      ack = gnt_q & bus.req_i;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        idx = PW'((int'(rr_q) + i) % NREQ);
        if (!found && bus.req_i[idx]) begin
          ack[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  // Steer the winning requester's fields onto the beat path.
  always_comb begin
    sel     = '0;
    sel_rd  = '0;
    sel_dat = '0;
    sel_len = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (ack[k]) begin
        sel     = PW'(k);
        sel_rd  = bus.rd_i[k*RWID +: RWID];
        sel_dat = bus.dat_i[k*WID +: WID];
        sel_len = bus.len_i[k*LENW +: LENW];
      end
    end
    xfer      = |ack;
    beat_addr = (state_q == BURST) ? wa_q : sel_rd;
  end

  // Registered write port, burst bookkeeping and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rfwr_q   <= 1'b0;
      wa_q     <= '0;
      dat_q    <= '0;
      elem_q   <= '0;
      gnt_q    <= '0;
      rr_q     <= '0;
      remain_q <= '0;
    end else begin
      rfwr_q <= xfer && (beat_addr != R0_ADDR);
      if (xfer) begin
        wa_q  <= beat_addr;
        dat_q <= sel_dat;
        if (state_q == IDLE) begin
          elem_q   <= '0;
          gnt_q    <= ack;
          rr_q     <= (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
          remain_q <= (sel_len > LENW'(1)) ? sel_len - LENW'(1) : '0;
        end else begin
          elem_q   <= elem_q + 1'b1;
          remain_q <= remain_q - 1'b1;
        end
      end
    end
  end

  assign bus.ack_o  = ack;
  assign bus.rfwr_o = rfwr_q;
  assign bus.wa_o   = wa_q;
  assign bus.i_o    = dat_q;
  assign bus.elem_o = elem_q;
  assign bus.gnt_o  = gnt_q;
  assign bus.busy_o = (state_q == BURST);

endmodule

// File: tb/tb_any1_rf_wr_arbiter.sv
// Scoreboard bench for the regfile write arbiter: the stimulus process runs a
// transaction-level model of the arbitration rules and queues the expected
// write-port state for every clock; an independent monitor pops and compares.
module tb_any1_rf_wr_arbiter;

  localparam int NREQ = 4;
  localparam int WID  = 64;
  localparam int RWID = 10;
  localparam int LENW = 8;
  localparam logic [9:0] R0 = 10'h3C0;

  typedef struct {
    logic        wr;
    logic [9:0]  wa;
    logic [63:0] dat;
    logic [7:0]  elem;
    logic [3:0]  gnt;
    logic        busy;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;

  any1_rf_wr_arbiter_if #(.NREQ(NREQ), .WID(WID), .RWID(RWID), .LENW(LENW)) bus ();

  any1_rf_wr_arbiter #(.NREQ(NREQ), .WID(WID), .RWID(RWID), .LENW(LENW)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;
  exp_t exp_q[$];

  logic [3:0]  req_v;
  logic [9:0]  rd_v[4];
  logic [63:0] dat_v[4];
  logic [7:0]  len_v[4];
  logic [3:0]  last_ack;

  // Reference model: who owns the port, beats still owed, next in rotation,
  // and the values the write port is currently showing.
  int          m_owner;
  int          m_left;
  int          m_rr;
  logic [9:0]  m_wa;
  logic [9:0]  m_lat;
  logic [63:0] m_dat;
  logic [7:0]  m_elem;
  logic [3:0]  m_gnt;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_owner = -1;
    m_left  = 0;
    m_rr    = 0;
    m_wa    = '0;
    m_lat   = '0;
    m_dat   = '0;
    m_elem  = '0;
    m_gnt   = '0;
  endtask

  // One clock of stimulus: drive at the falling edge, check the ack the model
  // predicts, and queue the write-port state expected after the next rising edge.
  task automatic applyStimulus();
    logic [3:0] exp_ack;
    logic       hit;
    int         k;
    int         n;
    exp_t       e;
    @(negedge clk_i);
    bus.req_i = req_v;
    for (int j = 0; j < NREQ; j++) begin
      bus.rd_i[j*RWID +: RWID]  = rd_v[j];
      bus.dat_i[j*WID +: WID]   = dat_v[j];
      bus.len_i[j*LENW +: LENW] = len_v[j];
    end
    #1;
    exp_ack = '0;
    hit = 1'b0;
    k = 0;
    if (m_owner >= 0) begin
      if (req_v[m_owner]) begin
        exp_ack = 4'(1) << m_owner;
        k = m_owner;
        hit = 1'b1;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!hit && req_v[(m_rr + i) % NREQ]) begin
          k = (m_rr + i) % NREQ;
          exp_ack = 4'(1) << k;
          hit = 1'b1;
        end
      end
    end
    checkOutput("ack", 64'(bus.ack_o), 64'(exp_ack));
    last_ack = exp_ack;
    e.wr = 1'b0;
    if (hit) begin
      if (m_owner < 0) begin
        m_wa   = rd_v[k];
        m_elem = '0;
        m_gnt  = exp_ack;
        m_rr   = (k + 1) % NREQ;
        n = (len_v[k] == 0) ? 1 : int'(len_v[k]);
        if (n > 1) begin
          m_owner = k;
          m_left  = n - 1;
          m_lat   = rd_v[k];
        end
      end else begin
        m_wa   = m_lat;
        m_elem = m_elem + 8'd1;
        m_left = m_left - 1;
        if (m_left == 0) m_owner = -1;
      end
      m_dat = dat_v[k];
      e.wr  = (m_wa != R0);
    end
    e.wa   = m_wa;
    e.dat  = m_dat;
    e.elem = m_elem;
    e.gnt  = m_gnt;
    e.busy = (m_owner >= 0);
    exp_q.push_back(e);
    chk_en = 1'b1;
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear at once.
  task automatic doReset();
    @(negedge clk_i);
    chk_en = 1'b0;
    rst_i  = 1'b0;
    #1;
    checkOutput("rst_rfwr", 64'(bus.rfwr_o), 64'd0);
    checkOutput("rst_wa",   64'(bus.wa_o),   64'd0);
    checkOutput("rst_i",    bus.i_o,         64'd0);
    checkOutput("rst_elem", 64'(bus.elem_o), 64'd0);
    checkOutput("rst_gnt",  64'(bus.gnt_o),  64'd0);
    checkOutput("rst_busy", 64'(bus.busy_o), 64'd0);
    exp_q.delete();
    modelReset();
    req_v = '0;
    bus.req_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic setReq(input int k, input logic [9:0] rd, input logic [63:0] dat, input logic [7:0] len);
    req_v[k] = 1'b1;
    rd_v[k]  = rd;
    dat_v[k] = dat;
    len_v[k] = len;
  endtask

  // Monitor: one expected write-port state per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #2;
      if (chk_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL scoreboard: got no expectation, expected one queued at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rfwr", 64'(bus.rfwr_o), 64'(e.wr));
          checkOutput("wa",   64'(bus.wa_o),   64'(e.wa));
          checkOutput("data", bus.i_o,         e.dat);
          checkOutput("elem", 64'(bus.elem_o), 64'(e.elem));
          checkOutput("gnt",  64'(bus.gnt_o),  64'(e.gnt));
          checkOutput("busy", 64'(bus.busy_o), 64'(e.busy));
        end
      end
    end
  end

  // Hard time limit so the bench always ends.
  initial begin
    #2000000;
    n_errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    req_v = '0;
    last_ack = '0;
    for (int k = 0; k < NREQ; k++) begin
      rd_v[k] = '0; dat_v[k] = '0; len_v[k] = 8'd1;
    end
    bus.req_i = '0; bus.rd_i = '0; bus.dat_i = '0; bus.len_i = '0;
    modelReset();
    doReset();

    $display("[TB] single scalar write");
    setReq(0, {4'd15, 6'd5}, 64'hDEAD, 8'd1);
    applyStimulus();
    checkOutput("t1_ack0", 64'(bus.ack_o[0]), 64'd1);
    req_v = '0;
    applyStimulus();
    checkOutput("t1_rfwr", 64'(bus.rfwr_o), 64'd1);
    checkOutput("t1_wa",   64'(bus.wa_o),   64'h3C5);
    checkOutput("t1_data", bus.i_o,         64'hDEAD);
    checkOutput("t1_gnt",  64'(bus.gnt_o),  64'h1);

    $display("[TB] all requesters held, single beats");
    for (int k = 0; k < NREQ; k++) setReq(k, 10'(k + 1), 64'(100 + k), 8'd1);
    repeat (5) applyStimulus();
    req_v = '0;
    applyStimulus();

    $display("[TB] stalled burst from requester 2");
    setReq(2, {4'd0, 6'd7}, 64'hA0, 8'd4);
    applyStimulus();
    setReq(0, 10'h011, 64'hB0, 8'd1);
    dat_v[2] = 64'hA1;
    applyStimulus();
    dat_v[2] = 64'hA2;
    applyStimulus();
    req_v[2] = 1'b0;
    repeat (2) begin
      applyStimulus();
      checkOutput("t3_stall_ack", 64'(bus.ack_o), 64'd0);
    end
    req_v[2] = 1'b1;
    dat_v[2] = 64'hA3;
    applyStimulus();
    checkOutput("t3_busy_last", 64'(bus.busy_o), 64'd1);
    req_v[2] = 1'b0;
    applyStimulus();
    checkOutput("t3_elem3", 64'(bus.elem_o), 64'd3);
    checkOutput("t3_owner0", 64'(bus.ack_o), 64'h1);
    req_v = '0;
    applyStimulus();

    $display("[TB] r0 discard");
    setReq(1, R0, 64'h55, 8'd1);
    applyStimulus();
    req_v = '0;
    applyStimulus();
    checkOutput("t4_rfwr", 64'(bus.rfwr_o), 64'd0);
    checkOutput("t4_gnt",  64'(bus.gnt_o),  64'h2);

    $display("[TB] zero length acts as one beat");
    setReq(3, 10'h123, 64'h77, 8'd0);
    applyStimulus();
    req_v = '0;
    applyStimulus();
    checkOutput("t5_busy", 64'(bus.busy_o), 64'd0);

    $display("[TB] reset in the middle of a burst");
    setReq(2, 10'h045, 64'hC0, 8'd8);
    repeat (3) applyStimulus();
    doReset();
    for (int k = 0; k < NREQ; k++) setReq(k, 10'(k + 40), 64'(200 + k), 8'd1);
    applyStimulus();
    checkOutput("t6_ack", 64'(bus.ack_o), 64'h1);
    req_v = '0;
    applyStimulus();

    $display("[TB] random traffic");
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (last_ack[k]) begin
          req_v[k] = (($urandom % 4) != 0);
          dat_v[k] = {$urandom, $urandom};
          rd_v[k]  = (($urandom % 8) == 0) ? R0 : 10'($urandom);
          len_v[k] = 8'($urandom % 6);
        end else if (req_v[k]) begin
          if (($urandom % 16) == 0) req_v[k] = 1'b0;
        end else if (($urandom % 3) == 0) begin
          setReq(k, (($urandom % 8) == 0) ? R0 : 10'($urandom), {$urandom, $urandom}, 8'($urandom % 6));
        end
      end
      applyStimulus();
    end

    req_v = '0;
    repeat (3) applyStimulus();
    @(posedge clk_i);
    #3;
    chk_en = 1'b0;
    checkOutput("drain", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
